// File: rtl/elevator_pkg.sv
// ============================================================
// elevator_pkg : shared scheduler state encoding and size defaults
// Revision 1.0
// ============================================================
`default_nettype none

package elevator_pkg;

    localparam int c_NUM_FLOORS_DEF = 10;
    localparam int c_FLOOR_W_DEF    = 4;

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_SERVE_UP   = 2'd1;
    localparam logic [1:0] c_SERVE_DOWN = 2'd2;
    localparam logic [1:0] c_DWELL      = 2'd3;

endpackage

`default_nettype wire

// File: rtl/floor_call_scheduler_if.sv
// ============================================================
// floor_call_scheduler_if : buttons/car feedback in, target and status out
// Revision 1.0
// ============================================================
`default_nettype none

interface floor_call_scheduler_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = c_NUM_FLOORS_DEF,
    parameter int FLOOR_W    = c_FLOOR_W_DEF
);
    logic [NUM_FLOORS-1:0] call_btn;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  car_idle;
    logic [FLOOR_W-1:0]    requested_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  busy;
    logic                  dir_up;

    modport master (
        output call_btn, current_floor, car_idle,
        input  requested_floor, pending, busy, dir_up
    );

    modport slave (
        input  call_btn, current_floor, car_idle,
        output requested_floor, pending, busy, dir_up
    );
endinterface

`default_nettype wire

// File: rtl/call_sync_edge.sv
// ============================================================
// call_sync_edge : 2-flop synchroniser with rising-edge press pulse
// Revision 1.0
// ============================================================
`default_nettype none

module call_sync_edge #(
    parameter int WIDTH = 10
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire  [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_pulse
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;
endmodule

`default_nettype wire

// File: rtl/floor_call_scheduler.sv
// ============================================================
// floor_call_scheduler : LOOK scheduler over a pending-call bitmap
// Revision 1.0
// ============================================================
`default_nettype none

module floor_call_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = c_NUM_FLOORS_DEF,
    parameter int FLOOR_W      = c_FLOOR_W_DEF,
    parameter int DWELL_CYCLES = 16
) (
    input wire clk,
    input wire rst_n,
    floor_call_scheduler_if.slave bus
);
    localparam int                 c_CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DWELL_CYCLES - 1);

    logic [1:0]            r_state, w_state_nxt;
    logic [FLOOR_W-1:0]    r_req, w_req_nxt;
    logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt;
    logic [NUM_FLOORS-1:0] w_pulse, w_here;
    logic                  r_dir_up, w_dir_nxt;
    logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                  w_park, w_reselect, w_pref_up;
    logic                  w_any_above, w_any_below, w_at_pend, w_at_press, w_arrive;
    logic [FLOOR_W-1:0]    w_lo_above, w_hi_below, w_cur;

    assign w_cur = bus.current_floor;

    call_sync_edge #(.WIDTH(NUM_FLOORS)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.call_btn),
        .o_pulse (w_pulse)
    );

    // Nearest pending call on each side of the car; an out-of-range floor has no w_here bit.
    always_comb begin
        w_here      = '0;
        w_any_above = 1'b0;
        w_any_below = 1'b0;
        w_lo_above  = '0;
        w_hi_below  = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (r_pending[i] && (FLOOR_W'(i) > w_cur)) begin
                w_any_above = 1'b1;
                w_lo_above  = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_here[i] = (FLOOR_W'(i) == w_cur);
            if (r_pending[i] && (FLOOR_W'(i) < w_cur)) begin
                w_any_below = 1'b1;
                w_hi_below  = FLOOR_W'(i);
            end
        end
    end

    assign w_at_pend  = |(r_pending & w_here);
    assign w_at_press = |(w_pulse & w_here);
    assign w_arrive   = bus.car_idle && (w_cur == r_req) && (|w_here) &&
                        ((r_state == c_SERVE_UP) || (r_state == c_SERVE_DOWN));

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_dir_nxt   = r_dir_up;
        w_cnt_nxt   = r_cnt;
        w_park      = 1'b0;
        w_reselect  = 1'b0;
        w_pref_up   = r_dir_up;
        case (r_state)
            c_IDLE: begin
                w_req_nxt = w_cur;
                w_cnt_nxt = '0;
                if (w_at_pend || w_at_press) begin
                    w_state_nxt = c_DWELL;
                    w_park      = 1'b1;
                end else begin
                    w_reselect = 1'b1;
                    w_pref_up  = 1'b1;
                end
            end
            c_SERVE_UP, c_SERVE_DOWN: begin
                if (w_arrive) begin
                    w_state_nxt = c_DWELL;
                    w_park      = 1'b1;
                    w_req_nxt   = w_cur;
                    w_cnt_nxt   = '0;
                end else if (w_at_pend && (r_req == w_cur)) begin
                    // Car is at its target but not yet stopped: hold the target.
                    w_req_nxt = r_req;
                end else if ((r_state == c_SERVE_UP) && w_any_above) begin
                    w_req_nxt = w_lo_above;
                end else if ((r_state == c_SERVE_DOWN) && w_any_below) begin
                    w_req_nxt = w_hi_below;
                end else begin
                    w_reselect = 1'b1;
                    w_pref_up  = (r_state == c_SERVE_UP);
                end
            end
            default: begin
                w_req_nxt = w_cur;
                w_park    = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt  = '0;
                    w_reselect = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
        endcase

        if (w_reselect) begin
            if (w_pref_up && w_any_above) begin
                w_state_nxt = c_SERVE_UP;
                w_dir_nxt   = 1'b1;
                w_req_nxt   = w_lo_above;
            end else if (w_any_below) begin
                w_state_nxt = c_SERVE_DOWN;
                w_dir_nxt   = 1'b0;
                w_req_nxt   = w_hi_below;
            end else if (w_any_above) begin
                w_state_nxt = c_SERVE_UP;
                w_dir_nxt   = 1'b1;
                w_req_nxt   = w_lo_above;
            end else begin
                w_state_nxt = c_IDLE;
                w_req_nxt   = w_cur;
            end
        end
    end

    // While parked, the local bit is cleared and a same-cycle press there is absorbed.
    assign w_pending_nxt = (r_pending | w_pulse) & ~(w_park ? w_here : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_req     <= '0;
            r_pending <= '0;
            r_dir_up  <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_pending <= w_pending_nxt;
            r_dir_up  <= w_dir_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.requested_floor = r_req;
    assign bus.pending         = r_pending;
    assign bus.busy            = (r_state != c_IDLE);
    assign bus.dir_up          = r_dir_up;
endmodule

`default_nettype wire
